// File: rtl/image_frame_loader.sv
`timescale 1ns/1ps
// image_frame_loader
//   Writable frame buffer feeding the MNIST inference pipeline. Pixels arrive
//   as a raster stream over valid/ready, are converted to the network's
//   16-bit fixed-point input format and stored. A complete frame fires a
//   one-cycle net_start, after which the buffer is locked until net_done.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   pix_data/valid/last pixel stream in (raster order), pix_ready out
//   rd_addr, rd_data    ROM-style read port, 1-cycle registered latency
//   net_start, net_done start pulse out, network-finished in
//   busy                frame locked while the network runs
//   frame_err           one-cycle pulse on a short or long frame
//   frame_count         frames handed to the network (wraps)
module image_frame_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10,
  parameter int FRAC_BITS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  input  logic              pix_last,
  output logic              pix_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              net_start,
  input  logic              net_done,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam int                SHIFT    = FRAC_BITS - 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIRE, S_BUSY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ready_q, busy_q, start_q;
  logic [15:0]       rd_data_q;
  logic [15:0]       wdata;
  logic              accept;

  logic [15:0] mem [NUM_PIXELS];

  // ready_q is high exactly when state_q == S_LOAD, so it alone qualifies a beat.
  assign accept = pix_valid & ready_q;
  assign wdata  = 16'(pix_data) << SHIFT;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (pix_last) begin
              cnt_d   = cnt_q + 16'd1;
              state_d = S_FIRE;
            end else begin
              err_d = 1'b1;               // long frame: pixel kept, restart
            end
          end else if (pix_last) begin
            err_d = 1'b1;                 // short frame: restart at index 0
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FIRE: state_d = S_BUSY;           // net_done here is deliberately ignored
      S_BUSY: if (net_done) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs are registered from next state, so they track
  // the state register with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= (state_d == S_LOAD);
      busy_q  <= (state_d == S_FIRE) || (state_d == S_BUSY);
      start_q <= (state_d == S_FIRE);
    end
  end

  // Buffer contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept) mem[idx_q] <= wdata;
  end

  // Non-blocking read of mem gives read-first behaviour on a same-address write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   rd_data_q <= '0;
    else if (rd_addr <= LAST_IDX) rd_data_q <= mem[rd_addr];
    else                        rd_data_q <= '0;
  end

  assign pix_ready   = ready_q;
  assign busy        = busy_q;
  assign net_start   = start_q;
  assign frame_err   = err_q;
  assign frame_count = cnt_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_image_frame_loader.sv
`timescale 1ns/1ps
module tb_image_frame_loader;
  localparam int NP = 784;

  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_valid = 1'b0, pix_last = 1'b0, net_done = 1'b0;
  logic [9:0] rd_addr = '0;

  logic        pr8, ns8, bz8, fe8, pr12, ns12, bz12, fe12;
  logic [15:0] rd8, fc8, rd12, fc12;

  image_frame_loader #(.NUM_PIXELS(NP), .ADDR_W(10), .FRAC_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pr8), .rd_addr(rd_addr), .rd_data(rd8),
    .net_start(ns8), .net_done(net_done), .busy(bz8), .frame_err(fe8),
    .frame_count(fc8));

  image_frame_loader #(.NUM_PIXELS(NP), .ADDR_W(10), .FRAC_BITS(12)) dut12 (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pr12), .rd_addr(rd_addr), .rd_data(rd12),
    .net_start(ns12), .net_done(net_done), .busy(bz12), .frame_err(fe12),
    .frame_count(fc12));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m [NP];

  typedef struct { bit st; int cnt; } ev_t;
  typedef struct { logic [15:0] e8; logic [15:0] e12; int a; } rd_t;
  ev_t ev_q[$];
  rd_t rd_q[$];
  logic rd_req = 1'b0, rd_req_d = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: read results and start/error pulses.
  always @(negedge clk) begin : mon
    ev_t e;
    rd_t r;
    if (rd_req_d) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk($sformatf("rd8[%0d]", r.a), {16'h0, rd8}, {16'h0, r.e8});
        chk($sformatf("rd12[%0d]", r.a), {16'h0, rd12}, {16'h0, r.e12});
      end
    end
    if (ns8 | fe8 | ns12 | fe12) begin
      if (ev_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ev_unexpected actual=start%0b/err%0b required=none", ns8, fe8);
      end else begin
        e = ev_q.pop_front();
        chk("ev_start8", {31'h0, ns8}, {31'h0, e.st});
        chk("ev_err8", {31'h0, fe8}, {31'h0, !e.st});
        chk("ev_start12", {31'h0, ns12}, {31'h0, e.st});
        chk("ev_err12", {31'h0, fe12}, {31'h0, !e.st});
        if (e.st) begin
          chk("ev_count8", {16'h0, fc8}, e.cnt);
          chk("ev_count12", {16'h0, fc12}, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pixf(input int mode, input int i);
    case (mode)
      0: return 8'(i);
      1: return 8'(i * 3);
      2: return 8'(i ^ 32'h5A);
      3: return (i == 0) ? 8'hAA : 8'(i + 7);
      4: return (i == 0) ? 8'h77 : ((i == 500) ? 8'hFF : 8'(i ^ 32'h5A));
      default: return 8'(255 - i);
    endcase
  endfunction

  // One beat; addr is where the spec says this beat lands.
  task automatic send(input logic [7:0] d, input bit last, input int addr, input bit gaps);
    int n = 0;
    bit r = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) begin pix_valid = 1'b0; tick(); end
    pix_valid = 1'b1; pix_data = d; pix_last = last;
    while (!r && n < 200) begin
      @(negedge clk); r = pr8;
      @(posedge clk); #1; n++;
    end
    if (!r) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_ready required=accept addr=%0d", addr);
    end else m[addr] = 32'(d);
  endtask

  task automatic frame(input int n, input int last_at, input int mode, input bit gaps);
    for (int i = 0; i < n; i++) send(pixf(mode, i), i == last_at, i, gaps);
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_t r;
    logic [7:0] p;
    p = (a < NP) ? 8'(m[a]) : 8'h0;
    r.e8 = {8'h0, p}; r.e12 = {4'h0, p, 4'h0}; r.a = a;
    rd_q.push_back(r);
    rd_addr = 10'(a); rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_ready", {31'h0, pr8}, 0);
    chk("rst_busy", {31'h0, bz8}, 0);
    chk("rst_start", {31'h0, ns8}, 0);
    chk("rst_err", {31'h0, fe8}, 0);
    chk("rst_count", {16'h0, fc8}, 0);
    chk("rst_rddata", {16'h0, rd8}, 0);
    rst = 1'b1; tick();
    chk("ready_after_reset", {31'h0, pr8}, 1);

    // Frame 1: continuous valid, pix_data = idx[7:0].
    ev_q.push_back('{1'b1, 1});
    frame(NP, NP - 1, 0, 1'b0);
    chk("start_next_cycle", {31'h0, ns8}, 1);
    chk("count1", {16'h0, fc8}, 1);
    tick();
    chk("start_one_pulse", {31'h0, ns8}, 0);
    chk("busy_after_fire", {30'h0, bz8, bz12}, 3);
    chk("ready_low_busy", {31'h0, pr8}, 0);
    rd(300); rd(0); rd(783);

    // Backpressure while busy: 0xAA held, must not be taken.
    pix_valid = 1'b1; pix_data = 8'hAA; pix_last = 1'b0;
    repeat (5) tick();
    chk("ready_held_low", {30'h0, pr8, pr12}, 0);
    rd(0);
    net_done = 1'b1; tick(); net_done = 1'b0;
    chk("ready_after_done", {31'h0, pr8}, 1);
    chk("busy_after_done", {31'h0, bz8}, 0);

    // Frame 2 starts with the held 0xAA; net_done during FIRE is ignored.
    ev_q.push_back('{1'b1, 2});
    frame(NP, NP - 1, 3, 1'b0);
    net_done = 1'b1; tick(); net_done = 1'b0;
    repeat (3) tick();
    chk("done_in_fire_ignored", {31'h0, bz8}, 1);
    rd(0); rd(1); rd(783);
    net_done = 1'b1; tick(); net_done = 1'b0;

    // Short frame: last on beat 99.
    ev_q.push_back('{1'b0, 0});
    frame(100, 99, 1, 1'b0);
    chk("short_err_pulse", {31'h0, fe8}, 1);
    chk("short_no_start", {31'h0, ns8}, 0);
    ev_q.push_back('{1'b1, 3});
    frame(NP, NP - 1, 1, 1'b0);
    chk("count3", {16'h0, fc8}, 3);
    tick();
    rd(0); rd(99); rd(783);
    net_done = 1'b1; tick(); net_done = 1'b0;

    // Long frame with random gaps; beat 784 lands at addr 0.
    ev_q.push_back('{1'b0, 0});
    frame(NP, -1, 2, 1'b1);
    chk("long_err_pulse", {31'h0, fe8}, 1);
    ev_q.push_back('{1'b1, 4});
    frame(NP, NP - 1, 4, 1'b1);
    chk("count4", {16'h0, fc8}, 4);
    tick();
    rd(0); rd(500); rd(783); rd(800); rd(1023);

    // Reset mid-BUSY: async clear.
    rst = 1'b0; #1;
    chk("rstbusy_busy", {31'h0, bz8}, 0);
    chk("rstbusy_ready", {31'h0, pr8}, 0);
    chk("rstbusy_count", {16'h0, fc8}, 0);
    chk("rstbusy_rddata", {16'h0, rd8}, 0);
    tick(); rst = 1'b1; tick();

    // Reset mid-frame at beat 400: no start for the aborted frame.
    frame(400, -1, 0, 1'b0);
    rst = 1'b0; #1;
    chk("rstload_ready", {31'h0, pr8}, 0);
    chk("rstload_err", {31'h0, fe8}, 0);
    tick(); rst = 1'b1; tick();
    ev_q.push_back('{1'b1, 1});
    frame(NP, NP - 1, 5, 1'b0);
    chk("post_reset_count", {16'h0, fc8}, 1);
    chk("post_reset_start", {31'h0, ns8}, 1);
    tick();
    rd(10); rd(783);

    repeat (4) tick();
    chk("ev_queue_empty", ev_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
